vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 109 ++++++++++
 tb/tb_vga_sync_gen.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: a pixel enable at half the clk rate drives the H/V counters,
// and one registered output stage aligns sync, blanking and color on the same pixel.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  pixelRGB,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        vgaHS,
  output logic        vgaVS,
  output logic        vgaBlankN,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic        r_pixEn;
  logic [10:0] r_hcnt, r_vcnt;
  logic        r_sof, r_hs, r_vs, r_blankN;
  logic [3:0]  r_r, r_g, r_b;

  logic        w_hwrap, w_vwrap, w_vis, w_hsync, w_vsync;
  logic [10:0] w_hnext, w_vnext;

  always_comb begin
    w_hwrap = (r_hcnt == H_LAST);
    w_vwrap = (r_vcnt == V_LAST);
    w_hnext = w_hwrap ? 11'd0 : r_hcnt + 11'd1;
    w_vnext = w_vwrap ? 11'd0 : r_vcnt + 11'd1;
    // Decoded from the pre-increment counts so the registered stage describes
    // the pixel whose color is being sampled on this tick.
    w_vis   = (r_hcnt < H_VIS) && (r_vcnt < V_VIS);
    w_hsync = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
    w_vsync = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_pixEn <= 1'b0;
      r_hcnt  <= 11'd0;
      r_vcnt  <= 11'd0;
      r_sof   <= 1'b0;
    end else begin
      r_pixEn <= ~r_pixEn;
      r_sof   <= r_pixEn & w_hwrap & w_vwrap;
      if (r_pixEn) begin
        r_hcnt <= w_hnext;
        if (w_hwrap) r_vcnt <= w_vnext;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hs     <= 1'b1;
      r_vs     <= 1'b1;
      r_blankN <= 1'b0;
      r_r      <= 4'd0;
      r_g      <= 4'd0;
      r_b      <= 4'd0;
    end else if (r_pixEn) begin
      r_hs     <= ~w_hsync;
      r_vs     <= ~w_vsync;
      r_blankN <= w_vis;
      if (w_vis) begin
        r_r <= {pixelRGB[7:5], pixelRGB[7]};
        r_g <= {pixelRGB[4:2], pixelRGB[4]};
        r_b <= {pixelRGB[1:0], pixelRGB[1:0]};
      end else begin
        r_r <= 4'd0;
        r_g <= 4'd0;
        r_b <= 4'd0;
      end
    end
  end

  assign pixelX       = r_hcnt;
  assign pixelY       = r_vcnt;
  assign startOfFrame = r_sof;
  assign vgaHS        = r_hs;
  assign vgaVS        = r_vs;
  assign vgaBlankN    = r_blankN;
  assign vgaR         = r_r;
  assign vgaG         = r_g;
  assign vgaB         = r_b;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (30x15) so whole frames fit in a short run;
// expected values come from a clk-count model of the raster.
module tb_vga_sync_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = 2 * HT * VT;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [7:0]  pixelRGB = 8'd0;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, vgaHS, vgaVS, vgaBlankN;
  logic [3:0]  vgaR, vgaG, vgaB;

  int checks = 0;
  int failures = 0;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .resetN(resetN), .pixelRGB(pixelRGB),
    .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .vgaHS(vgaHS), .vgaVS(vgaVS), .vgaBlankN(vgaBlankN),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB)
  );

  always #5 clk = ~clk;

  // Model state: clk edges since reset release, and the color latched on the latest tick.
  int         mk;
  logic [7:0] mrgb;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mk   <= 0;
      mrgb <= 8'd0;
    end else begin
      mk <= mk + 1;
      if ((mk + 1) % 2 == 0) mrgb <= pixelRGB;
    end
  end

  // Pixel ticks fall on even edge counts; n ticks have elapsed after edge mk.
  function automatic int m_ticks();
    return mk / 2;
  endfunction
  function automatic logic [10:0] m_x();
    return 11'(m_ticks() % HT);
  endfunction
  function automatic logic [10:0] m_y();
    return 11'((m_ticks() / HT) % VT);
  endfunction
  function automatic int m_px();
    return (m_ticks() - 1) % HT;
  endfunction
  function automatic int m_py();
    return ((m_ticks() - 1) / HT) % VT;
  endfunction
  function automatic logic m_blank();
    return m_ticks() >= 1 && m_px() < HA && m_py() < VA;
  endfunction
  function automatic logic m_hs();
    return !(m_ticks() >= 1 && m_px() >= HA + HF && m_px() < HA + HF + HS);
  endfunction
  function automatic logic m_vs();
    return !(m_ticks() >= 1 && m_py() >= VA + VF && m_py() < VA + VF + VS);
  endfunction
  function automatic logic m_sof();
    return mk % 2 == 0 && m_ticks() >= 1 && m_ticks() % (HT * VT) == 0;
  endfunction
  function automatic logic [3:0] m_r();
    int c;
    c = int'(mrgb[7:5]);
    return m_blank() ? 4'(c * 2 + c / 4) : 4'd0;
  endfunction
  function automatic logic [3:0] m_g();
    int c;
    c = int'(mrgb[4:2]);
    return m_blank() ? 4'(c * 2 + c / 4) : 4'd0;
  endfunction
  function automatic logic [3:0] m_b();
    int c;
    c = int'(mrgb[1:0]);
    return m_blank() ? 4'(c * 5) : 4'd0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pixelRGB = 8'($urandom);
      @(posedge clk); #1;
      checks += 9;
      if (pixelX !== 11'd0)      begin failures++; $display("FAIL reset_x got=%0d exp=0", pixelX); end
      if (pixelY !== 11'd0)      begin failures++; $display("FAIL reset_y got=%0d exp=0", pixelY); end
      if (vgaHS !== 1'b1)        begin failures++; $display("FAIL reset_hs got=%b exp=1", vgaHS); end
      if (vgaVS !== 1'b1)        begin failures++; $display("FAIL reset_vs got=%b exp=1", vgaVS); end
      if (vgaBlankN !== 1'b0)    begin failures++; $display("FAIL reset_blank got=%b exp=0", vgaBlankN); end
      if (startOfFrame !== 1'b0) begin failures++; $display("FAIL reset_sof got=%b exp=0", startOfFrame); end
      if (vgaR !== 4'd0)         begin failures++; $display("FAIL reset_r got=%h exp=0", vgaR); end
      if (vgaG !== 4'd0)         begin failures++; $display("FAIL reset_g got=%h exp=0", vgaG); end
      if (vgaB !== 4'd0)         begin failures++; $display("FAIL reset_b got=%h exp=0", vgaB); end
    end
  endtask

  // Random colors over several frames; every output compared every clk, plus per-frame totals.
  task automatic test_random_frames();
    int nsof = 0, last_sof = -1, hs_low = 0, vs_low = 0, nerr = 0;
    do_reset();
    for (int c = 1; c <= 3 * FRAME_CLKS; c++) begin
      pixelRGB = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (pixelX !== m_x() || pixelY !== m_y() || vgaHS !== m_hs() || vgaVS !== m_vs() ||
          vgaBlankN !== m_blank() || startOfFrame !== m_sof() ||
          vgaR !== m_r() || vgaG !== m_g() || vgaB !== m_b()) begin
        failures++;
        if (nerr++ < 10)
          $display("FAIL frame_outputs clk=%0d got x=%0d y=%0d hs=%b vs=%b bn=%b sof=%b rgb=%h%h%h exp x=%0d y=%0d hs=%b vs=%b bn=%b sof=%b rgb=%h%h%h",
                   c, pixelX, pixelY, vgaHS, vgaVS, vgaBlankN, startOfFrame, vgaR, vgaG, vgaB,
                   m_x(), m_y(), m_hs(), m_vs(), m_blank(), m_sof(), m_r(), m_g(), m_b());
      end
      if (startOfFrame === 1'b1) begin
        if (last_sof >= 0) begin
          checks++;
          if (c - last_sof != FRAME_CLKS) begin
            failures++;
            $display("FAIL sof_spacing got=%0d exp=%0d", c - last_sof, FRAME_CLKS);
          end
        end
        last_sof = c;
        nsof++;
      end
      if (c % 2 == 0 && c <= FRAME_CLKS) begin
        if (vgaHS === 1'b0) hs_low++;
        if (vgaVS === 1'b0) vs_low++;
      end
      @(negedge clk);
    end
    checks += 3;
    if (nsof != 3)       begin failures++; $display("FAIL sof_count got=%0d exp=3", nsof); end
    if (hs_low != HS*VT) begin failures++; $display("FAIL hs_low_ticks got=%0d exp=%0d", hs_low, HS*VT); end
    if (vs_low != VS*HT) begin failures++; $display("FAIL vs_low_ticks got=%0d exp=%0d", vs_low, VS*HT); end
  endtask

  task automatic test_color_directed();
    pixelRGB = 8'b101_011_10;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (vgaR !== 4'hB)      begin failures++; $display("FAIL color00_r got=%h exp=b", vgaR); end
    if (vgaG !== 4'h6)      begin failures++; $display("FAIL color00_g got=%h exp=6", vgaG); end
    if (vgaB !== 4'hA)      begin failures++; $display("FAIL color00_b got=%h exp=a", vgaB); end
    if (vgaBlankN !== 1'b1) begin failures++; $display("FAIL color00_blank got=%b exp=1", vgaBlankN); end
    repeat (2 * HA) @(posedge clk);
    #1;
    checks += 2;
    if ({vgaR, vgaG, vgaB} !== 12'h000) begin
      failures++; $display("FAIL colorHA_rgb got=%h exp=000", {vgaR, vgaG, vgaB});
    end
    if (vgaBlankN !== 1'b0) begin failures++; $display("FAIL colorHA_blank got=%b exp=0", vgaBlankN); end
  endtask

  task automatic test_dark_background();
    int lit = 0, bad = 0;
    pixelRGB = 8'hE0;
    do_reset();
    for (int c = 1; c <= FRAME_CLKS; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        if ({vgaR, vgaG, vgaB} != 12'h000) lit++;
        if (vgaBlankN && {vgaR, vgaG, vgaB} !== 12'hF00) bad++;
      end
    end
    checks += 2;
    if (lit != HA * VA) begin failures++; $display("FAIL dark_lit_ticks got=%0d exp=%0d", lit, HA*VA); end
    if (bad != 0)       begin failures++; $display("FAIL dark_color got=%0d bad exp=0", bad); end
  endtask

  task automatic test_midreset();
    int tx, ty, guard, nsof, nerr;
    bit hit;
    tx = $urandom_range(0, HT - 1);
    ty = $urandom_range(1, VT - 1);
    hit = 0;
    do_reset();
    for (guard = 0; guard < 2 * FRAME_CLKS && !hit; guard++) begin
      @(posedge clk); #1;
      if (m_x() == 11'(tx) && m_y() == 11'(ty)) hit = 1;
    end
    checks++;
    if (!hit || pixelX !== 11'(tx) || pixelY !== 11'(ty)) begin
      failures++; $display("FAIL midreset_reach got=(%0d,%0d) exp=(%0d,%0d)", pixelX, pixelY, tx, ty);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (pixelX !== 11'd0 || pixelY !== 11'd0 || vgaHS !== 1'b1 || vgaVS !== 1'b1 ||
        vgaBlankN !== 1'b0 || startOfFrame !== 1'b0 || {vgaR, vgaG, vgaB} !== 12'h000) begin
      failures++;
      $display("FAIL midreset_async got x=%0d y=%0d hs=%b vs=%b bn=%b sof=%b rgb=%h exp all reset",
               pixelX, pixelY, vgaHS, vgaVS, vgaBlankN, startOfFrame, {vgaR, vgaG, vgaB});
    end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    nsof = 0;
    nerr = 0;
    for (int c = 1; c < FRAME_CLKS; c++) begin
      @(posedge clk); #1;
      if (startOfFrame === 1'b1) nsof++;
      if (pixelX !== m_x() || pixelY !== m_y()) begin
        if (nerr++ < 5) $display("FAIL midreset_count clk=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                                 c, pixelX, pixelY, m_x(), m_y());
      end
    end
    checks += 2;
    if (nerr != 0) failures++;
    if (nsof != 0) begin failures++; $display("FAIL midreset_spurious_sof got=%0d exp=0", nsof); end
    @(posedge clk); #1;
    checks++;
    if (startOfFrame !== 1'b1) begin failures++; $display("FAIL midreset_first_sof got=%b exp=1", startOfFrame); end
  endtask

  initial begin
    test_reset();
    test_random_frames();
    test_color_directed();
    test_dark_background();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
